// File: rtl/ysyx_23060096_imm_dec_stage.sv
// Immediate-decode pipeline stage: classifies the RISC-V instruction format,
// forms the extended immediate, and registers the result behind a two-entry
// (main + skid) buffer with a valid/ready handshake.
module ysyx_23060096_imm_dec_stage #(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst
);

  localparam logic [2:0] FmtI   = 3'b000;
  localparam logic [2:0] FmtU   = 3'b001;
  localparam logic [2:0] FmtS   = 3'b010;
  localparam logic [2:0] FmtB   = 3'b011;
  localparam logic [2:0] FmtJ   = 3'b100;
  localparam logic [2:0] FmtZ   = 3'b101;
  localparam logic [2:0] FmtR   = 3'b110;
  localparam logic [2:0] FmtIll = 3'b111;

  logic [6:0]      opcode;
  logic [31:0]     immI, immU, immS, immB, immJ;
  logic [XLEN-1:0] decImm;
  logic [2:0]      decFmt;

  logic            mainValid, skidValid;
  logic [XLEN-1:0] mainImm, skidImm;
  logic [2:0]      mainFmt, skidFmt;
  logic [XLEN-1:0] mainPc, skidPc;
  logic [31:0]     mainInst, skidInst;

  logic            accept, drain;

  assign opcode = in_inst[6:0];

  // 32-bit sign-extended forms; widened to XLEN by a signed size cast below.
  assign immI = {{20{in_inst[31]}}, in_inst[31:20]};
  assign immU = {in_inst[31:12], 12'b0};
  assign immS = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign immB = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign immJ = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Format classification and immediate selection from the opcode.
  always_comb begin
    decFmt = FmtIll;
    decImm = '0;
    unique case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        decFmt = FmtI;
        decImm = XLEN'($signed(immI));
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          decFmt = FmtI;
          decImm = XLEN'($signed(immI));
        end
      end
      7'b0110111, 7'b0010111: begin
        decFmt = FmtU;
        decImm = XLEN'($signed(immU));
      end
      7'b0100011: begin
        decFmt = FmtS;
        decImm = XLEN'($signed(immS));
      end
      7'b1100011: begin
        decFmt = FmtB;
        decImm = XLEN'($signed(immB));
      end
      7'b1101111: begin
        decFmt = FmtJ;
        decImm = XLEN'($signed(immJ));
      end
      7'b0110011: decFmt = FmtR;
      7'b0111011: begin
        if (XLEN == 64) decFmt = FmtR;
      end
      7'b1110011: begin
        // CSR addresses are unsigned, so the I-form field is zero-extended here.
        if (CSR_EN) begin
          if (in_inst[14]) begin
            decFmt = FmtZ;
            decImm = XLEN'(in_inst[19:15]);
          end else begin
            decFmt = FmtI;
            decImm = XLEN'(in_inst[31:20]);
          end
        end
      end
      default: ;
    endcase
  end

  // in_ready comes straight from the skid flag so it is a registered output.
  assign in_ready = !skidValid;
  assign accept   = in_valid && !skidValid && !flush;
  assign drain    = mainValid && out_ready;

  // Main/skid buffer update; a full skid can only coexist with a blocked input.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainImm   <= '0;
      mainFmt   <= '0;
      mainPc    <= '0;
      mainInst  <= '0;
      skidImm   <= '0;
      skidFmt   <= '0;
      skidPc    <= '0;
      skidInst  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (drain) begin
      if (skidValid) begin
        mainImm   <= skidImm;
        mainFmt   <= skidFmt;
        mainPc    <= skidPc;
        mainInst  <= skidInst;
        skidValid <= 1'b0;
      end else if (accept) begin
        mainImm   <= decImm;
        mainFmt   <= decFmt;
        mainPc    <= in_pc;
        mainInst  <= in_inst;
      end else begin
        mainValid <= 1'b0;
      end
    end else if (accept) begin
      if (!mainValid) begin
        mainImm   <= decImm;
        mainFmt   <= decFmt;
        mainPc    <= in_pc;
        mainInst  <= in_inst;
        mainValid <= 1'b1;
      end else begin
        skidImm   <= decImm;
        skidFmt   <= decFmt;
        skidPc    <= in_pc;
        skidInst  <= in_inst;
        skidValid <= 1'b1;
      end
    end
  end

  assign out_valid = mainValid;
  assign out_imm   = mainImm;
  assign out_fmt   = mainFmt;
  assign out_pc    = mainPc;
  assign out_inst  = mainInst;

endmodule

// File: tb/tb_ysyx_23060096_imm_dec_stage.sv
// Scoreboard bench for the immediate-decode stage. Three instances share the
// same stimulus: XLEN=32/CSR, XLEN=64/CSR and XLEN=32 without CSR decode.
module tb_ysyx_23060096_imm_dec_stage;

  localparam logic [63:0] PcBase = 64'h0000_0001_8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt64;
    logic [2:0]  fmt32;
    logic [2:0]  fmtNc;
  } vec_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, outReady;
  logic [31:0] inInst;
  logic [63:0] inPc;

  logic        rdy32, vld32, rdy64, vld64, rdyNc, vldNc;
  logic [31:0] imm32, pc32, inst32, immNc, pcNc, instNc, inst64;
  logic [63:0] imm64, pc64;
  logic [2:0]  fmt32, fmt64, fmtNc;

  vec_t vecs [16];
  exp_t q32[$], q64[$], qNc[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;

  always #5 clk = ~clk;

  ysyx_23060096_imm_dec_stage #(.XLEN(32), .CSR_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(rdy32),
    .in_inst(inInst), .in_pc(inPc[31:0]), .out_valid(vld32), .out_ready(outReady),
    .out_imm(imm32), .out_fmt(fmt32), .out_pc(pc32), .out_inst(inst32));

  ysyx_23060096_imm_dec_stage #(.XLEN(64), .CSR_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(rdy64),
    .in_inst(inInst), .in_pc(inPc), .out_valid(vld64), .out_ready(outReady),
    .out_imm(imm64), .out_fmt(fmt64), .out_pc(pc64), .out_inst(inst64));

  ysyx_23060096_imm_dec_stage #(.XLEN(32), .CSR_EN(1'b0)) dutNc (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(rdyNc),
    .in_inst(inInst), .in_pc(inPc[31:0]), .out_valid(vldNc), .out_ready(outReady),
    .out_imm(immNc), .out_fmt(fmtNc), .out_pc(pcNc), .out_inst(instNc));

  function automatic logic [63:0] pcOf(input int i);
    return PcBase + 64'(4 * i);
  endfunction

  // cfg: 0 = XLEN32/CSR, 1 = XLEN64/CSR, 2 = XLEN32 no CSR
  function automatic exp_t mkExp(input int i, input int cfg);
    exp_t e;
    logic [63:0] pc;
    pc = pcOf(i);
    e.inst = vecs[i].inst;
    if (cfg == 1) begin
      e.fmt = vecs[i].fmt64;
      e.pc  = pc;
      e.imm = vecs[i].imm;
    end else begin
      e.fmt = (cfg == 0) ? vecs[i].fmt32 : vecs[i].fmtNc;
      e.pc  = {32'b0, pc[31:0]};
      e.imm = {32'b0, vecs[i].imm[31:0]};
    end
    if (e.fmt == 3'b111) e.imm = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic popCheck(input string name, input int which, input exp_t act);
    exp_t e;
    bit   empty;
    empty = 1'b0;
    e = '0;
    case (which)
      0: if (q32.size() == 0) empty = 1'b1; else e = q32.pop_front();
      1: if (q64.size() == 0) empty = 1'b1; else e = q64.pop_front();
      default: if (qNc.size() == 0) empty = 1'b1; else e = qNc.pop_front();
    endcase
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL %s unexpected output inst=%h imm=%h, required no output", name, act.inst, act.imm);
    end else if (act !== e) begin
      errors++;
      $display("FAIL %s got imm=%h fmt=%0d pc=%h inst=%h required imm=%h fmt=%0d pc=%h inst=%h",
               name, act.imm, act.fmt, act.pc, act.inst, e.imm, e.fmt, e.pc, e.inst);
    end
  endtask

  // Present vector i and hold it until accepted (checked just before the edge).
  task automatic sendVec(input int i);
    inValid = 1'b1;
    inInst  = vecs[i].inst;
    inPc    = pcOf(i);
    for (int b = 0; b < 40; b++) begin
      @(negedge clk);
      if (rdy32) begin
        q32.push_back(mkExp(i, 0));
        q64.push_back(mkExp(i, 1));
        qNc.push_back(mkExp(i, 2));
        @(posedge clk);
        #1;
        inValid = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout vec=%0d got in_ready=0 required 1", i);
    inValid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int b = 0; b < 60; b++) begin
      if (q32.size() == 0 && q64.size() == 0 && qNc.size() == 0) return;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL %s drain_timeout got pending=%0d required 0", name, q32.size());
  endtask

  task automatic clearQueues();
    q32.delete();
    q64.delete();
    qNc.delete();
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'd0, 3'd0};
    vecs[1]  = '{32'h0080006F, 64'h0000_0000_0000_0008, 3'd4, 3'd4, 3'd4};
    vecs[2]  = '{32'h3002D0F3, 64'h0000_0000_0000_0005, 3'd5, 3'd5, 3'd7};
    vecs[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd1, 3'd1, 3'd1};
    vecs[4]  = '{32'hFFE0809B, 64'hFFFF_FFFF_FFFF_FFFE, 3'd0, 3'd7, 3'd7};
    vecs[5]  = '{32'hFE20AE23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 3'd2, 3'd2};
    vecs[6]  = '{32'h00208863, 64'h0000_0000_0000_0010, 3'd3, 3'd3, 3'd3};
    vecs[7]  = '{32'h000000E3, 64'h0000_0000_0000_0800, 3'd3, 3'd3, 3'd3};
    vecs[8]  = '{32'h002081B3, 64'h0000_0000_0000_0000, 3'd6, 3'd6, 3'd6};
    vecs[9]  = '{32'h002081BB, 64'h0000_0000_0000_0000, 3'd6, 3'd7, 3'd7};
    vecs[10] = '{32'h0000007F, 64'h0000_0000_0000_0000, 3'd7, 3'd7, 3'd7};
    vecs[11] = '{32'hF14020F3, 64'h0000_0000_0000_0F14, 3'd0, 3'd0, 3'd7};
    vecs[12] = '{32'h801FF0EF, 64'hFFFF_FFFF_FFFF_F800, 3'd4, 3'd4, 3'd4};
    vecs[13] = '{32'h7FF32283, 64'h0000_0000_0000_07FF, 3'd0, 3'd0, 3'd0};
    vecs[14] = '{32'h12345017, 64'h0000_0000_1234_5000, 3'd1, 3'd1, 3'd1};
    vecs[15] = '{32'hFE001FE3, 64'hFFFF_FFFF_FFFF_FFFE, 3'd3, 3'd3, 3'd3};

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    inInst = '0; inPc = '0;

    // Monitor: an output is consumed when out_valid && out_ready at the next edge.
    fork
      forever begin
        @(negedge clk);
        if (!rst && outReady) begin
          if (vld32) popCheck("out32", 0, '{{32'b0, imm32}, fmt32, {32'b0, pc32}, inst32});
          if (vld64) popCheck("out64", 1, '{imm64, fmt64, pc64, inst64});
          if (vldNc) popCheck("outNc", 2, '{{32'b0, immNc}, fmtNc, {32'b0, pcNc}, instNc});
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(vld32), 64'd0);
    chk("rst_in_ready", 64'(rdy32), 64'd1);
    chk("rst_out_imm", 64'(imm32), 64'd0);
    chk("rst_out_fmt", 64'(fmt32), 64'd0);
    chk("rst_out_pc", pc64, 64'd0);
    chk("rst_out_inst", 64'(inst32), 64'd0);
    chk("rst64_valid_ready", {62'b0, vld64, rdy64}, 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming at full rate.
    sendVec(0);
    chk("latency_valid", 64'(vld32), 64'd1);
    chk("latency_inst", 64'(inst32), 64'hFFF00093);
    for (int i = 1; i < 16; i++) sendVec(i);
    chk("stream_no_stall", 64'(stalls), 64'd0);
    waitDrain("stream");

    // Backpressure: A,B,C with downstream stalled, then released.
    @(posedge clk);
    #1;
    outReady = 1'b0;
    fork
      begin
        sendVec(5);
        sendVec(6);
        sendVec(7);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_in_ready_low", 64'(rdy32), 64'd0);
        chk("bp_hold_a", 64'(inst32), 64'hFE20AE23);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_next_b", 64'(inst32), 64'h00208863);
        chk("bp_ready_back", 64'(rdy32), 64'd1);
        @(posedge clk);
        #1;
        chk("bp_next_c", 64'(inst32), 64'h000000E3);
        @(posedge clk);
        #1;
        chk("bp_empty", {62'b0, vld32, rdy32}, 64'd1);
      end
    join
    waitDrain("backpressure");

    // Flush with main and skid full and a new input presented.
    outReady = 1'b0;
    sendVec(15);
    sendVec(2);
    chk("fl_skid_full", 64'(rdy32), 64'd0);
    inValid = 1'b1;
    inInst  = vecs[3].inst;
    inPc    = pcOf(3);
    flush   = 1'b1;
    @(posedge clk);
    #1;
    flush   = 1'b0;
    inValid = 1'b0;
    clearQueues();
    chk("fl_out_valid", 64'(vld32), 64'd0);
    chk("fl_in_ready", 64'(rdy32), 64'd1);
    chk("fl64_valid", 64'(vld64), 64'd0);
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sendVec(1);
    waitDrain("post_flush");

    // Reset while an output is stalled.
    outReady = 1'b0;
    sendVec(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clearQueues();
    chk("mrst_out_valid", 64'(vld32), 64'd0);
    chk("mrst_in_ready", 64'(rdy32), 64'd1);
    chk("mrst_out_imm", 64'(imm32), 64'd0);
    chk("mrst_out_inst", 64'(inst32), 64'd0);
    rst = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    sendVec(3);
    chk("mrst_latency_valid", 64'(vld32), 64'd1);
    chk("mrst_latency_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    waitDrain("post_reset");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1);
  end

endmodule
